// File: rtl/pid_hdng_ctrl_if.sv
// Heading-controller bus: navigation side (master) drives headings/speed, controller (slave) returns wheel speeds and status.
// Latency: none, pure wiring.
// Backpressure: none; every signal is a level or single-cycle strobe.
interface pid_hdng_ctrl_if #(
    parameter int HDNG_W = 12,
    parameter int SPD_W  = 11
);
    logic                     moving;
    logic                     hdng_vld;
    logic                     clr_integ;
    logic signed [HDNG_W-1:0] dsrd_hdng;
    logic signed [HDNG_W-1:0] actl_hdng;
    logic [SPD_W-1:0]         frwrd_spd;
    logic signed [SPD_W:0]    lft_spd;
    logic signed [SPD_W:0]    rght_spd;
    logic                     spd_vld;
    logic                     at_hdng;
    logic                     settled;

    modport master (
        output moving, hdng_vld, clr_integ, dsrd_hdng, actl_hdng, frwrd_spd,
        input  lft_spd, rght_spd, spd_vld, at_hdng, settled
    );

    modport slave (
        input  moving, hdng_vld, clr_integ, dsrd_hdng, actl_hdng, frwrd_spd,
        output lft_spd, rght_spd, spd_vld, at_hdng, settled
    );
endinterface

// File: rtl/pid_hdng_ctrl.sv
// Pipelined heading PID: wrapped/saturated error -> P + I (+ D when PID_DTERM_EN is defined) -> clamped wheel speeds, plus settled FSM.
// Latency: hdng_vld to spd_vld/speeds 3 cycles, at_hdng 2 cycles, settled 2 cycles at the earliest.
// Backpressure: none; a sample may arrive every cycle and outputs are never stalled.
module pid_hdng_ctrl #(
    parameter int HDNG_W    = 12,
    parameter int SPD_W     = 11,
    parameter int ERR_SAT_W = 10,
    parameter int P_COEFF   = 3,
    parameter int D_COEFF   = 14,
    parameter int I_SHIFT   = 4,
    parameter int AT_THR    = 30,
    parameter int HYST      = 8,
    parameter int SETTLE_N  = 8
) (
    input logic           clk,
    input logic           rst,
    pid_hdng_ctrl_if.slave bus
);
    localparam int INTEG_W = ERR_SAT_W + 6;
    localparam int DIFF_W  = ERR_SAT_W - 2;
    localparam int P_W     = ERR_SAT_W + 5;
    localparam int D_W     = DIFF_W + 6;
    localparam int SUM_W   = ERR_SAT_W + 8;
    localparam int WS_W    = SUM_W + 1;
    localparam int WHL_W   = SPD_W + 1;
    localparam int CNT_W   = $clog2(SETTLE_N + 1);

    localparam logic signed [ERR_SAT_W-1:0] ESAT_MAX = {1'b0, {(ERR_SAT_W-1){1'b1}}};
    localparam logic signed [ERR_SAT_W-1:0] ESAT_MIN = {1'b1, {(ERR_SAT_W-1){1'b0}}};
    localparam logic signed [HDNG_W-1:0]    EMAX_X   = HDNG_W'(ESAT_MAX);
    localparam logic signed [HDNG_W-1:0]    EMIN_X   = HDNG_W'(ESAT_MIN);
    localparam logic signed [WHL_W-1:0]     WHL_MAX  = {1'b0, {(WHL_W-1){1'b1}}};
    localparam logic signed [WHL_W-1:0]     WHL_MIN  = {1'b1, {(WHL_W-1){1'b0}}};
    localparam logic signed [WS_W-1:0]      WMAX_X   = WS_W'(WHL_MAX);
    localparam logic signed [WS_W-1:0]      WMIN_X   = WS_W'(WHL_MIN);
    localparam logic signed [4:0]           P_K      = 5'(P_COEFF);
    localparam logic [ERR_SAT_W-1:0]        AT_LIM   = ERR_SAT_W'(AT_THR);
    localparam logic [ERR_SAT_W-1:0]        LEAVE_LIM = ERR_SAT_W'(AT_THR + HYST);
    localparam logic [CNT_W-1:0]            CNT_LAST = CNT_W'(SETTLE_N - 1);

    if (P_COEFF > 15 || D_COEFF > 31 || SETTLE_N < 1 || HDNG_W <= ERR_SAT_W) begin : g_param_chk
        $error("pid_hdng_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, SETTLED = 2'd2} state_t;

    logic signed [HDNG_W-1:0]    error_q;
    logic                        vld1, vld2;
    logic signed [ERR_SAT_W-1:0] err_sat;
    logic [ERR_SAT_W-1:0]        abs_err;
    logic                        in_thr, out_hyst;
    logic signed [P_W-1:0]       p_q;
    logic signed [INTEG_W-1:0]   integ;
    logic signed [INTEG_W:0]     integ_sum;
    logic                        integ_ovf;
    logic signed [D_W-1:0]       d_q;
    logic signed [SUM_W-1:0]     pid_sum, pid8;
    logic signed [WS_W-1:0]      lft_full, rght_full;
    logic signed [WHL_W-1:0]     lft_q, rght_q;
    logic                        spd_vld_q, at_hdng_q, settled_o;
    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    function automatic logic signed [WHL_W-1:0] clamp_whl(input logic signed [WS_W-1:0] x);
        if (x > WMAX_X)      return WHL_MAX;
        else if (x < WMIN_X) return WHL_MIN;
        else                 return x[WHL_W-1:0];
    endfunction

    // Heading difference wraps naturally in HDNG_W bits; only the result is saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= '0;
            vld1    <= 1'b0;
        end else begin
            error_q <= bus.actl_hdng - bus.dsrd_hdng;
            vld1    <= bus.hdng_vld;
        end
    end

    always_comb begin
        if (error_q > EMAX_X)      err_sat = ESAT_MAX;
        else if (error_q < EMIN_X) err_sat = ESAT_MIN;
        else                       err_sat = error_q[ERR_SAT_W-1:0];
        abs_err  = err_sat[ERR_SAT_W-1] ? -err_sat : err_sat;
        in_thr   = abs_err < AT_LIM;
        out_hyst = abs_err >= LEAVE_LIM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q  <= '0;
            vld2 <= 1'b0;
        end else begin
            p_q  <= P_W'(P_K) * P_W'(err_sat);
            vld2 <= vld1;
        end
    end

    // Anti-windup: a sample that would overflow is discarded rather than wrapped.
    assign integ_sum = (INTEG_W+1)'(integ) + (INTEG_W+1)'(err_sat);
    assign integ_ovf = integ_sum[INTEG_W] ^ integ_sum[INTEG_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           integ <= '0;
        else if (!bus.moving || bus.clr_integ) integ <= '0;
        else if (vld1 && !integ_ovf)       integ <= integ_sum[INTEG_W-1:0];
    end

`ifdef PID_DTERM_EN
    localparam logic signed [DIFF_W-1:0]  DSAT_MAX = {1'b0, {(DIFF_W-1){1'b1}}};
    localparam logic signed [DIFF_W-1:0]  DSAT_MIN = {1'b1, {(DIFF_W-1){1'b0}}};
    localparam logic signed [ERR_SAT_W:0] DMAX_X   = (ERR_SAT_W+1)'(DSAT_MAX);
    localparam logic signed [ERR_SAT_W:0] DMIN_X   = (ERR_SAT_W+1)'(DSAT_MIN);
    localparam logic signed [5:0]         D_K      = 6'(D_COEFF);

    logic signed [ERR_SAT_W-1:0] h0, h1;
    logic signed [ERR_SAT_W:0]   diff_full;
    logic signed [DIFF_W-1:0]    diff_sat;

    always_comb begin
        diff_full = (ERR_SAT_W+1)'(err_sat) - (ERR_SAT_W+1)'(h1);
        if (diff_full > DMAX_X)      diff_sat = DSAT_MAX;
        else if (diff_full < DMIN_X) diff_sat = DSAT_MIN;
        else                         diff_sat = diff_full[DIFF_W-1:0];
    end

    // Derivative spans two samples; history ignores moving/clr_integ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h0  <= '0;
            h1  <= '0;
            d_q <= '0;
        end else if (vld1) begin
            h0  <= err_sat;
            h1  <= h0;
            d_q <= D_W'(D_K) * D_W'(diff_sat);
        end
    end
`else
    assign d_q = '0;
`endif

    always_comb begin
        pid_sum   = SUM_W'(p_q) + SUM_W'(integ >>> I_SHIFT) + SUM_W'(d_q);
        pid8      = pid_sum >>> 3;
        lft_full  = WS_W'($signed({1'b0, bus.frwrd_spd})) + WS_W'(pid8);
        rght_full = WS_W'($signed({1'b0, bus.frwrd_spd})) - WS_W'(pid8);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_q     <= '0;
            rght_q    <= '0;
            spd_vld_q <= 1'b0;
            at_hdng_q <= 1'b0;
        end else begin
            lft_q     <= bus.moving ? clamp_whl(lft_full) : '0;
            rght_q    <= bus.moving ? clamp_whl(rght_full) : '0;
            spd_vld_q <= vld2 & bus.moving;
            at_hdng_q <= in_thr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.moving) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                    cnt_d   = '0;
                end
                TRACK: begin
                    if (vld1) begin
                        if (!in_thr) begin
                            cnt_d = '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_d = SETTLED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                SETTLED: begin
                    if (vld1 && out_hyst) begin
                        state_d = TRACK;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb settled_o = (state_q == SETTLED);

    assign bus.lft_spd  = lft_q;
    assign bus.rght_spd = rght_q;
    assign bus.spd_vld  = spd_vld_q;
    assign bus.at_hdng  = at_hdng_q;
    assign bus.settled  = settled_o;
endmodule

// File: tb/tb_pid_hdng_ctrl.sv
// Bench for pid_hdng_ctrl: directed scenarios plus randomized streams against an integer reference model.
module tb_pid_hdng_ctrl;
    localparam int AT_THR   = 30;
    localparam int HYST     = 8;
    localparam int SETTLE_N = 8;
    localparam int P_K      = 3;
    localparam int D_K      = 14;
    localparam int I_SH     = 4;
`ifdef PID_DTERM_EN
    localparam int G_L = 832, G_R = 192, C_R = 1727;
`else
    localparam int G_L = 610, G_R = 414, C_R = 1949;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pid_hdng_ctrl_if #(.HDNG_W(12), .SPD_W(11)) bus();
    pid_hdng_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int err;
        bit vld;
        bit mv;
        bit clr;
        int frw;
    } cyc_t;

    cyc_t hist[$];
    int   m_integ, m_dq, m_h0, m_h1, m_state, m_cnt;
    int   exp_lft, exp_rght;
    bit   exp_vld, exp_at, exp_set;

    function automatic int clampi(int x, int lo, int hi);
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    // Heading error: wrap the difference into signed 12 bits, then clamp to signed 10 bits.
    function automatic int err_of(logic [11:0] a, logic [11:0] d);
        int x;
        x = (int'(a) - int'(d)) & 4095;
        if (x > 2047) x = x - 4096;
        return clampi(x, -512, 511);
    endfunction

    function automatic logic [26:0] obs_vec();
        return {bus.lft_spd, bus.rght_spd, bus.spd_vld, bus.at_hdng, bus.settled};
    endfunction

    function automatic logic [26:0] exp_vec();
        return {12'(exp_lft), 12'(exp_rght), exp_vld, exp_at, exp_set};
    endfunction

    function automatic string dut_str();
        return $sformatf("lft=%0d rght=%0d vld=%0b at=%0b set=%0b",
                         bus.lft_spd, bus.rght_spd, bus.spd_vld, bus.at_hdng, bus.settled);
    endfunction

    function automatic string exp_str();
        return $sformatf("lft=%0d rght=%0d vld=%0b at=%0b set=%0b",
                         exp_lft, exp_rght, exp_vld, exp_at, exp_set);
    endfunction

    task automatic model_reset();
        cyc_t z;
        z = '{err: 0, vld: 1'b0, mv: 1'b0, clr: 1'b0, frw: 0};
        hist.delete();
        repeat (3) hist.push_front(z);
        m_integ = 0; m_dq = 0; m_h0 = 0; m_h1 = 0; m_state = 0; m_cnt = 0;
        exp_lft = 0; exp_rght = 0; exp_vld = 0; exp_at = 0; exp_set = 0;
    endtask

    // One clock: record this cycle's inputs, predict outputs for the next cycle, return at the negedge.
    task automatic step();
        cyc_t c, p1, p2;
        int   sum, pid, t;
        c.err = err_of(bus.actl_hdng, bus.dsrd_hdng);
        c.vld = bus.hdng_vld;
        c.mv  = bus.moving;
        c.clr = bus.clr_integ;
        c.frw = int'(bus.frwrd_spd);
        hist.push_front(c);
        void'(hist.pop_back());
        p1 = hist[1];
        p2 = hist[2];
        @(posedge clk);
        sum      = P_K * p2.err + (m_integ >>> I_SH) + m_dq;
        pid      = sum >>> 3;
        exp_lft  = c.mv ? clampi(c.frw + pid, -2048, 2047) : 0;
        exp_rght = c.mv ? clampi(c.frw - pid, -2048, 2047) : 0;
        exp_vld  = p2.vld && c.mv;
        exp_at   = iabs(p1.err) < AT_THR;
        if (!c.mv || c.clr) begin
            m_integ = 0;
        end else if (p1.vld) begin
            t = m_integ + p1.err;
            if (t <= 32767 && t >= -32768) m_integ = t;
        end
`ifdef PID_DTERM_EN
        if (p1.vld) begin
            m_dq = D_K * clampi(p1.err - m_h1, -128, 127);
            m_h1 = m_h0;
            m_h0 = p1.err;
        end
`endif
        if (!c.mv) begin
            m_state = 0; m_cnt = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_cnt = 0;
        end else if (m_state == 1) begin
            if (p1.vld) begin
                if (iabs(p1.err) < AT_THR) begin
                    m_cnt++;
                    if (m_cnt == SETTLE_N) begin m_state = 2; m_cnt = 0; end
                end else begin
                    m_cnt = 0;
                end
            end
        end else if (p1.vld && iabs(p1.err) >= AT_THR + HYST) begin
            m_state = 1; m_cnt = 0;
        end
        exp_set = (m_state == 2);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.moving = 0; bus.hdng_vld = 0; bus.clr_integ = 0;
        bus.dsrd_hdng = '0; bus.actl_hdng = '0; bus.frwrd_spd = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.moving = 1; bus.hdng_vld = 1; bus.clr_integ = 0;
        bus.dsrd_hdng = 12'sd5; bus.actl_hdng = 12'sd300; bus.frwrd_spd = 11'd700;
        repeat (3) @(negedge clk);
        model_reset();
        checks++;
        if (obs_vec() !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %s, required all zero", dut_str());
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %s, model %s", dut_str(), exp_str());
        end
        rst = 1'b0;
    endtask

    task automatic test_gain(input int frw, input int req_l, input int req_r, input string tag);
        apply_reset();
        bus.moving = 1;
        step();
        bus.actl_hdng = 12'h100; bus.frwrd_spd = 11'(frw); bus.hdng_vld = 1;
        step();
        bus.hdng_vld = 0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) step();
            checks++;
            if (bus.spd_vld !== (k == 3)) begin
                errors++;
                $display("FAIL %s_latency n+%0d: spd_vld=%0b required %0b", tag, k, bus.spd_vld, k == 3);
            end
        end
        checks++;
        if (bus.lft_spd !== 12'(req_l) || bus.rght_spd !== 12'(req_r)) begin
            errors++;
            $display("FAIL %s_speeds: lft=%0d rght=%0d required lft=%0d rght=%0d",
                     tag, bus.lft_spd, bus.rght_spd, req_l, req_r);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL %s_model: got %s, model %s", tag, dut_str(), exp_str());
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.moving = 1; bus.hdng_vld = 1;
        bus.dsrd_hdng = 12'h7F0; bus.actl_hdng = 12'h810;
        step(); step();
        checks++;
        if (bus.at_hdng !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL wrap_err32: got %s, required at=0 and model %s", dut_str(), exp_str());
        end
        bus.actl_hdng = 12'h80C;
        step(); step();
        checks++;
        if (bus.at_hdng !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL wrap_err28: got %s, required at=1 and model %s", dut_str(), exp_str());
        end
    endtask

    task automatic test_settle();
        apply_reset();
        bus.moving = 1; bus.hdng_vld = 1; bus.actl_hdng = 12'sd10; bus.frwrd_spd = 11'd400;
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++;
            if (bus.settled !== (k >= 9) || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL settle_rise step %0d: got %s, model %s", k, dut_str(), exp_str());
            end
        end
        bus.actl_hdng = 12'sd37;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.settled !== 1'b1 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL settle_hold37 step %0d: got %s, model %s", k, dut_str(), exp_str());
            end
        end
        bus.actl_hdng = 12'sd38;
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++;
            if (bus.settled !== (k == 1) || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL settle_leave38 step %0d: got %s, model %s", k, dut_str(), exp_str());
            end
        end
    endtask

    task automatic test_integ_sat();
        apply_reset();
        bus.moving = 1; bus.hdng_vld = 1; bus.actl_hdng = 12'sd511; bus.frwrd_spd = 11'd0;
        for (int k = 0; k < 20000; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL integ_run cyc %0d: got %s, model %s", k, dut_str(), exp_str());
            end
        end
        checks++;
        if (bus.lft_spd !== 12'sd447 || bus.rght_spd !== -12'sd447) begin
            errors++;
            $display("FAIL integ_frozen: lft=%0d rght=%0d required 447/-447", bus.lft_spd, bus.rght_spd);
        end
        bus.hdng_vld = 0; bus.clr_integ = 1;
        step();
        bus.clr_integ = 0;
        step();
        checks++;
        if (bus.lft_spd !== 12'sd191 || bus.rght_spd !== -12'sd191 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL integ_clear: got %s, required lft=191 rght=-191 model %s", dut_str(), exp_str());
        end
    endtask

    task automatic test_moving_drop();
        apply_reset();
        bus.moving = 1; bus.hdng_vld = 1; bus.actl_hdng = 12'sd5; bus.frwrd_spd = 11'd900;
        repeat (12) step();
        checks++;
        if (bus.settled !== 1'b1 || bus.spd_vld !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL drop_pre: got %s, model %s", dut_str(), exp_str());
        end
        bus.moving = 0;
        step();
        checks++;
        if (bus.lft_spd !== 12'sd0 || bus.rght_spd !== 12'sd0 || bus.settled !== 1'b0 ||
            bus.spd_vld !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL drop_zero: got %s, required zero speeds/settled", dut_str());
        end
        bus.moving = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drop_resume step %0d: got %s, model %s", k, dut_str(), exp_str());
            end
        end
    endtask

    task automatic test_rst_mid();
        apply_reset();
        bus.moving = 1; bus.hdng_vld = 1; bus.actl_hdng = 12'sd100; bus.frwrd_spd = 11'd300;
        repeat (10) step();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 27'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: got %s, required all zero", dut_str());
        end
        model_reset();
        bus.hdng_vld = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.hdng_vld = 1;
        step();
        bus.hdng_vld = 0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) step();
            checks++;
            if (bus.spd_vld !== (k == 3) || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rst_mid_restart n+%0d: got %s, model %s", k, dut_str(), exp_str());
            end
        end
    endtask

    task automatic test_random();
        int delta;
        apply_reset();
        for (int k = 0; k < 1500; k++) begin
            bus.moving    = ($urandom_range(0, 39) != 0);
            bus.hdng_vld  = ($urandom_range(0, 9) < 7);
            bus.clr_integ = ($urandom_range(0, 19) == 0);
            bus.frwrd_spd = 11'($urandom);
            bus.dsrd_hdng = 12'($urandom);
            case ($urandom_range(0, 2))
                0: delta = int'($urandom_range(0, 80)) - 40;
                1: delta = int'($urandom_range(0, 4095));
                default: delta = 2048 + int'($urandom_range(0, 64)) - 32;
            endcase
            bus.actl_hdng = 12'(int'(bus.dsrd_hdng) + delta);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %s, model %s", k, dut_str(), exp_str());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.moving = 0; bus.hdng_vld = 0; bus.clr_integ = 0;
        bus.dsrd_hdng = '0; bus.actl_hdng = '0; bus.frwrd_spd = '0;
        model_reset();
        test_reset();
        test_gain(32'h200, G_L, G_R, "gain");
        test_gain(32'h7FF, 2047, C_R, "clamp");
        test_wrap();
        test_settle();
        test_integ_sat();
        test_moving_drop();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pid_hdng_ctrl.md
# pid_hdng_ctrl

Parametrised, pipelined heading PID controller for the drive path. It converts desired and actual heading into signed left/right wheel speeds around a forward speed. Unlike the previous generation, it adds configurable widths and gains, registered and saturated outputs, an output-valid strobe, an integrator clear, and a debounced "settled" state machine. It sits between the heading sensor/navigation logic and the motor drive.

## Interface
- HDNG_W, 12, heading width (signed, modular)
- SPD_W, 11, unsigned forward speed width; wheel speeds are SPD_W+1 signed
- ERR_SAT_W, 10, saturated error width (signed)
- P_COEFF, 3, proportional gain (unsigned, 4 bits)
- D_COEFF, 14, derivative gain (unsigned, 5 bits)
- I_SHIFT, 4, integrator right-shift to form I term
- AT_THR, 30, at-heading threshold on |err_sat|
- HYST, 8, extra margin before leaving SETTLED
- SETTLE_N, 8, consecutive in-threshold valid samples to reach SETTLED (>=1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- moving  in  1  robot moving; low zeroes speeds and integrator
- hdng_vld  in  1  new actl_hdng sample this cycle
- clr_integ  in  1  synchronous integrator clear
- dsrd_hdng  in  HDNG_W  desired heading, signed
- actl_hdng  in  HDNG_W  actual heading, signed
- frwrd_spd  in  SPD_W  forward speed, unsigned
- lft_spd  out  SPD_W+1  left wheel speed, signed, registered
- rght_spd  out  SPD_W+1  right wheel speed, signed, registered
- spd_vld  out  1  one-cycle pulse: speeds reflect a new sample
- at_hdng  out  1  registered |err_sat| < AT_THR
- settled  out  1  high in SETTLED state

## Operation
- S1: error_q <= actl_hdng - dsrd_hdng, computed mod 2^HDNG_W (wraps, no saturation); vld1 <= hdng_vld.
- err_sat: error_q saturated to signed ERR_SAT_W (clamp to +2^(ERR_SAT_W-1)-1 / -2^(ERR_SAT_W-1)).
- S2 (every cycle): P_q <= P_COEFF*err_sat; vld2 <= vld1.
- Integrator: signed ERR_SAT_W+6 bits. Priority: !moving or clr_integ -> 0; else vld1 and no signed overflow -> integ + sext(err_sat); else hold. Overflow means freeze (anti-windup), never wrap.
- D: history h0/h1 update only when vld1 (h0<=err_sat, h1<=h0). diff = err_sat - h1, saturated to signed ERR_SAT_W-2; D_q <= D_COEFF*diff, registered when vld1 (holds otherwise).
- S3: sum = P_q + (integ >>> I_SHIFT) + D_q, full precision; pid8 = sum >>> 3. lft = frwrd_spd + pid8, rght = frwrd_spd - pid8, each clamped to signed SPD_W+1 range. Register outputs: moving ? clamped : 0. spd_vld <= vld2 & moving.
- at_hdng <= (|err_sat| < AT_THR), updated each cycle from S1.
- FSM states IDLE, TRACK, SETTLED; counter cnt:
  - IDLE: !moving. moving -> TRACK, cnt=0.
  - TRACK: on vld1, in-threshold -> cnt+1, else cnt=0; cnt reaches SETTLE_N -> SETTLED.
  - SETTLED: on vld1 with |err_sat| >= AT_THR+HYST -> TRACK, cnt=0.
  - Any state: !moving -> IDLE; clr_integ does not affect FSM.
- Reset: all registers 0; lft_spd=rght_spd=0, spd_vld=0, at_hdng=0, settled=0, FSM IDLE.

## Timing
- hdng_vld at cycle n -> spd_vld and the new speeds at n+3; at_hdng at n+2; settled at earliest n+2 (SETTLE_N=1).
- Full throughput: hdng_vld may be asserted every cycle.
- moving falling: speeds 0 and integrator 0 after the next edge; FSM enters IDLE the same edge.
- rst asserted mid-stream: all state cleared immediately; no spd_vld until 3 cycles after the first post-reset hdng_vld.
- clr_integ and vld1 in the same cycle: clear wins; sample is dropped from integrator (D history still updates).

## Configuration
- PID_DTERM_EN defined: D path (h0, h1, D_q) present as above.
- Not defined: D_q constant 0, history registers absent, PID = P + I only; all other timing unchanged.

## Test plan
- Defaults, moving=1, dsrd=0, actl=0x100, frwrd=0x200, single hdng_vld -> 3 cycles later spd_vld=1, lft=832, rght=192 (P 768, I 16, D 1778, pid8 320).
- Same stimulus, frwrd=0x7FF -> lft clamps to 0x7FF, rght=1727.
- dsrd=0x7F0, actl=0x810 -> error wraps to +32, at_hdng=0; actl=0x80C -> error +28, at_hdng=1.
- Error 10 held with hdng_vld every cycle -> settled rises on 8th in-threshold sample; error 37 keeps SETTLED, error 38 returns to TRACK.
- Error +511 held with hdng_vld for 20000 cycles -> integrator freezes at max positive, never wraps sign; clr_integ -> 0 next edge.
- moving dropped mid-stream -> speeds 0 and integrator 0 next edge, settled 0; rst pulse mid-stream -> all outputs 0 immediately.
